uart_rx: RTL

- UART receiver. Receive-side counterpart of the design's UART transmitter: 8N1 framing, LSB first, idle-high line.
- Oversamples the asynchronous serial input with the system clock and re-times it.
- Detects and validates the start bit at mid-bit, then samples each data and stop bit at mid-bit.
- Presents the received byte with a one-cycle valid strobe, or a framing-error strobe, to the downstream consumer (command decoder / FIFO).

---
 rtl/uart_rx_if.sv | 37 +++
 rtl/uart_rx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: signal bundle between the UART receiver and its environment.
//
// Handshake: there is no back-pressure. valid and frame_err are single-cycle
// strobes. The consumer must take data_out in the cycle where valid is high.
// data_out keeps its value between strobes. valid and frame_err are never high
// in the same cycle.
//
// Signals:
//   CLKS_PER_BIT  clocks per bit period (4..8191), sampled at frame start
//   rx            asynchronous serial line, idle high
//   data_out      last correctly framed byte
//   valid         one-cycle strobe: data_out updated with a good frame
//   frame_err     one-cycle strobe: stop bit sampled low
//   busy          receiver is inside a frame (state != IDLE)
//   dbg_state     current FSM state encoding, for observation only
// Modports: slave = receiver side, master = line driver / consumer side.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [12:0]           CLKS_PER_BIT;
  logic                  rx;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  frame_err;
  logic                  busy;
  logic [2:0]            dbg_state;

  modport slave (
    input  CLKS_PER_BIT, rx,
    output data_out, valid, frame_err, busy, dbg_state
  );

  modport master (
    output CLKS_PER_BIT, rx,
    input  data_out, valid, frame_err, busy, dbg_state
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
// The serial input goes through a two-flop synchronizer. The start bit is
// confirmed at mid-bit. Each data bit and the stop bit are then sampled one
// full bit period later, so every sample falls at mid-bit.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_rx_if.slave (CLKS_PER_BIT, rx in; data_out, valid,
//        frame_err, busy, dbg_state out)
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  state_t                r_state, w_state_next;
  logic                  r_sync1, r_sync2;
  logic [12:0]           r_clk_cnt, w_clk_cnt_next;
  logic [2:0]            r_bit_cnt, w_bit_cnt_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [DATA_WIDTH-1:0] r_data, w_data_next;
  logic [12:0]           r_cpb, w_cpb_next;
  logic                  r_valid, w_valid_next;
  logic                  r_ferr, w_ferr_next;

  logic                  w_rx_s;
  logic [12:0]           w_last;
  logic [12:0]           w_half;

  assign w_rx_s = r_sync2;
  assign w_last = r_cpb - 13'd1;
  // Half a bit period measured from the detected falling edge.
  assign w_half = w_last >> 1;

  // Two-flop synchronizer. It resets to the idle level so that reset does
  // not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_cpb     <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_data    <= w_data_next;
      r_cpb     <= w_cpb_next;
      r_valid   <= w_valid_next;
      r_ferr    <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_data_next    = r_data;
    w_cpb_next     = r_cpb;
    w_valid_next   = 1'b0;
    w_ferr_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_next   = S_START;
          w_clk_cnt_next = '0;
          // The bit period is frozen for the whole frame.
          w_cpb_next     = bus.CLKS_PER_BIT;
        end
      end

      S_START: begin
        if (r_clk_cnt == w_half) begin
          w_clk_cnt_next = '0;
          w_bit_cnt_next = '0;
          // If the line is high again at mid-start, treat it as a glitch.
          w_state_next   = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 13'd1;
        end
      end

      S_DATA: begin
        if (r_clk_cnt == w_last) begin
          w_shift_next[r_bit_cnt] = w_rx_s;
          w_clk_cnt_next          = '0;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 13'd1;
        end
      end

      S_STOP: begin
        if (r_clk_cnt == w_last) begin
          w_state_next   = S_DONE;
          w_clk_cnt_next = '0;
          if (w_rx_s) begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
          end else begin
            w_ferr_next  = 1'b1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 13'd1;
        end
      end

      // The FSM leaves the stop bit at its middle. A start edge that arrives
      // right after the stop bit therefore finds the FSM already back in IDLE.
      S_DONE:  w_state_next = S_IDLE;

      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.data_out  = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dbg_state = r_state;

endmodule
